// File: rtl/if_fetch_ctrl_pkg.sv
// rtl/if_fetch_ctrl_pkg.sv - shared types and constants for the instruction-fetch controller
package if_fetch_ctrl_pkg;

  localparam int INSTR_W          = 16;
  localparam int PC_W             = 16;
  localparam logic [15:0] PC_STEP = 16'd2;
  localparam int WAIT_MAX_DEFAULT = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_instr_buf.sv
// rtl/if_instr_buf.sv - one-entry instruction buffer between fetch and decode
module if_instr_buf
  import if_fetch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               consume,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;

  // flush beats load beats consume; a load in a consume cycle keeps the entry valid
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - fetch FSM, PC steering, redirect drain and memory watchdog
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_addr,
  output logic               pc_en,
  output logic               branch_taken,
  output logic [PC_W-1:0]    branch_addr,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_addr,
  output logic               fetch_fault
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  fetch_state_t     state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [PC_W-1:0]  drain_addr_q, drain_addr_d;

  logic req_raw;
  logic redirect_take;
  logic buf_valid;
  logic buf_load;
  logic buf_flush;
  logic buf_consume;

  assign buf_consume = buf_valid && id_ready;

  always_comb begin
    state_d       = state_q;
    drain_addr_d  = drain_addr_q;
    wait_cnt_d    = '0;
    req_raw       = 1'b0;
    redirect_take = 1'b0;
    imem_addr     = '0;
    pc_en         = 1'b0;
    branch_taken  = 1'b0;
    branch_addr   = '0;
    buf_load      = 1'b0;
    buf_flush     = 1'b0;

    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        req_raw   = !buf_valid || id_ready;
        imem_addr = pc_addr;
      end
      DRAIN: begin
        req_raw   = 1'b1;
        imem_addr = drain_addr_q;
        if (imem_ack) state_d = FETCH;
      end
      FAULT: buf_flush = 1'b1;
      default: state_d = BOOT;
    endcase

    redirect_take = redirect_valid && !rst && (state_q == FETCH || state_q == DRAIN);

    // An unacked request cannot be withdrawn, so a redirect parks it in DRAIN
    if (redirect_take) begin
      pc_en        = 1'b1;
      branch_taken = 1'b1;
      branch_addr  = redirect_addr;
      buf_flush    = 1'b1;
      if (state_q == FETCH && req_raw && !imem_ack) begin
        drain_addr_d = pc_addr;
        state_d      = DRAIN;
      end
    end else if (state_q == FETCH && req_raw && imem_ack) begin
      buf_load = 1'b1;
      pc_en    = 1'b1;
    end

    if (req_raw && !imem_ack) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
      if (wait_cnt_q == CNT_W'(WAIT_MAX - 1)) state_d = FAULT;
    end

    imem_req = req_raw && !rst;
    if (rst) begin
      pc_en        = 1'b0;
      branch_taken = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      wait_cnt_q   <= '0;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign fetch_fault = (state_q == FAULT);
  assign id_valid    = buf_valid;

  if_instr_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .consume    (buf_consume),
    .flush      (buf_flush),
    .load_instr (imem_rdata),
    .load_pc    (pc_addr),
    .valid      (buf_valid),
    .instr      (id_instr),
    .pc         (id_pc)
  );

endmodule
